// File: rtl/aes256_pkg.sv
// Shared constants for the AES-256 key expander: sizes, FSM states, Rcon and the S-box.
package aes256_pkg;

    localparam int NK     = 8;
    localparam int NR     = 14;
    localparam int NWORDS = 4 * (NR + 1);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    // Indexed by cnt/8; entry 0 is never used since expansion starts at word 8.
    localparam logic [0:7][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: independent S-box lookup on each byte lane of a 32-bit word.
module aes_subword
    import aes256_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic [8*NUM_LANES-1:0] x,
    output logic [8*NUM_LANES-1:0] y
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign y[8*i +: 8] = sbox(x[8*i +: 8]);
    end

endmodule

// File: rtl/aes256_key_expander.sv
// AES-256 key schedule: one expanded word per cycle into a 60-word array,
// with a registered round-key read port for the encryption core.
module aes256_key_expander
    import aes256_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         key_load,
    input  logic [255:0] key_in,
    input  logic [3:0]   enc_keyAddr,
    output logic [127:0] enc_key,
    output logic         busy,
    output logic         key_ready
);

    state_t                   state, state_nxt;
    logic [5:0]               cnt;
    logic [NWORDS-1:0][31:0]  w;
    logic                     load, step;
    logic [31:0]              prev, rot, sub_in, sub_out, t, w_new;
    logic [3:0]               rd_addr;
    logic [5:0]               rd_base;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (key_load) begin
                    load      = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (cnt == 6'(NWORDS - 1))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word byte 0 sits in the low byte, so RotWord is a right rotate by 8.
    assign prev   = w[cnt - 6'd1];
    assign rot    = {prev[7:0], prev[31:8]};
    assign sub_in = (cnt[2:0] == 3'd0) ? rot : prev;

    aes_subword #(.NUM_LANES(4)) u_subword (
        .x (sub_in),
        .y (sub_out)
    );

    always_comb begin
        t = prev;
        if (cnt[2:0] == 3'd0)
            t = sub_out ^ {24'h0, RCON[cnt[5:3]]};
        else if (cnt[2:0] == 3'd4)
            t = sub_out;
        w_new = w[cnt - 6'(NK)] ^ t;
    end

    // Address 15 is forced to zero below; clamp so the slice stays in range.
    assign rd_addr = (enc_keyAddr == 4'd15) ? 4'd0 : enc_keyAddr;
    assign rd_base = {rd_addr, 2'b00};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            w         <= '0;
            key_ready <= 1'b0;
            enc_key   <= '0;
        end else begin
            state     <= state_nxt;
            key_ready <= (state_nxt == DONE);
            if (load) begin
                w[NK-1:0] <= key_in;
                cnt       <= 6'(NK);
            end else if (step) begin
                w[cnt] <= w_new;
                cnt    <= cnt + 6'd1;
            end
            enc_key <= (enc_keyAddr == 4'd15) ? '0 : w[rd_base +: 4];
        end
    end

    assign busy = (state == EXPAND);

endmodule

// File: tb/tb_aes256_key_expander.sv
// Scoreboard bench for the AES-256 key expander: stimulus queues expectations, a monitor checks them.
module tb_aes256_key_expander;

    logic         clk = 1'b0;
    logic         resetn;
    logic         key_load;
    logic [255:0] key_in;
    logic [3:0]   enc_keyAddr;
    logic [127:0] enc_key;
    logic         busy;
    logic         key_ready;

    aes256_key_expander dut (
        .clk         (clk),
        .resetn      (resetn),
        .key_load    (key_load),
        .key_in      (key_in),
        .enc_keyAddr (enc_keyAddr),
        .enc_key     (enc_key),
        .busy        (busy),
        .key_ready   (key_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        int           kind;   // 0 enc_key, 1 key_ready, 2 busy
        logic [127:0] exp;
        logic [127:0] mask;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [127:0] ALL = {128{1'b1}};
    localparam logic [255:0] KEY_A_BE =
        256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    logic [7:0]  tsbox [256];
    logic [31:0] mw    [60];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tsbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw_be(input logic [31:0] v);
        return {tsbox[v[31:24]], tsbox[v[23:16]], tsbox[v[15:8]], tsbox[v[7:0]]};
    endfunction

    // Reference schedule in FIPS word order (first byte most significant).
    task automatic model(input logic [255:0] key_be);
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 8; i++) mw[i] = key_be[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = mw[i-1];
            if (i % 8 == 0) begin
                tmp = subw_be({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subw_be(tmp);
            end
            mw[i] = mw[i-8] ^ tmp;
        end
    endtask

    function automatic logic [127:0] bswap128(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = v[8*(15-k) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] bswap256(input logic [255:0] v);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = v[8*(31-k) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rk_exp(input int r);
        return bswap128({mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
    endfunction

    task automatic push(input int due, input int kind, input logic [127:0] exp,
                        input logic [127:0] mask, input string name);
        exp_t e;
        e.due = due; e.kind = kind; e.exp = exp; e.mask = mask; e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        logic [127:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                case (sb[i].kind)
                    0:       act = enc_key;
                    1:       act = {127'h0, key_ready};
                    default: act = {127'h0, busy};
                endcase
                checks++;
                if (((act & sb[i].mask) !== (sb[i].exp & sb[i].mask)) || sb[i].due != cyc) begin
                    failures++;
                    $display("FAIL %s cyc=%0d due=%0d got=%h expected=%h", sb[i].name, cyc,
                             sb[i].due, act & sb[i].mask, sb[i].exp & sb[i].mask);
                end
                sb.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse key_load for one cycle; t0 is the cycle in which it was driven.
    task automatic load_key(input logic [255:0] k, output int t0);
        t0       = cyc;
        key_load = 1'b1;
        key_in   = k;
        wait_cyc(1);
        key_load = 1'b0;
        key_in   = ~k;
    endtask

    task automatic push_timing(input int t0, input string tag);
        push(t0 + 1,  2, 128'd1, ALL, {tag, "_busy_start"});
        push(t0 + 52, 1, 128'd0, ALL, {tag, "_ready_early"});
        push(t0 + 52, 2, 128'd1, ALL, {tag, "_busy_last"});
        push(t0 + 53, 1, 128'd1, ALL, {tag, "_ready_rise"});
        push(t0 + 53, 2, 128'd0, ALL, {tag, "_busy_end"});
    endtask

    task automatic sweep(input string tag);
        for (int r = 0; r < 15; r++) begin
            enc_keyAddr = 4'(r);
            push(cyc + 1, 0, rk_exp(r), ALL, $sformatf("%s_rk%0d", tag, r));
            wait_cyc(1);
        end
        wait_cyc(1);
    endtask

    initial begin : stim
        int t0;
        logic [255:0] key_a;
        resetn      = 1'b0;
        key_load    = 1'b0;
        key_in      = '0;
        enc_keyAddr = 4'd0;
        key_a       = bswap256(KEY_A_BE);
        build_sbox();

        wait_cyc(2);
        push(cyc, 0, 128'd0, ALL, "rst_enc_key");
        push(cyc, 1, 128'd0, ALL, "rst_key_ready");
        push(cyc, 2, 128'd0, ALL, "rst_busy");
        wait_cyc(1);
        resetn = 1'b1;
        wait_cyc(2);

        // FIPS-197 A.3 key: timing, golden words, full sweep.
        model(KEY_A_BE);
        load_key(key_a, t0);
        push_timing(t0, "a");
        wait_cyc(53);
        enc_keyAddr = 4'd2;
        push(cyc + 1, 0, {96'h0, 32'h1154a39b}, {96'h0, 32'hffffffff}, "a_w8");
        wait_cyc(1);
        enc_keyAddr = 4'd0;
        push(cyc + 1, 0, bswap128(128'h603deb1015ca71be2b73aef0857d7781), ALL, "a_rk0_gold");
        wait_cyc(1);
        enc_keyAddr = 4'd14;
        push(cyc + 1, 0, bswap128(128'hfe4890d1e6188d0b046df344706c631e), ALL, "a_rk14_gold");
        wait_cyc(2);
        sweep("a");

        // Address 15 and per-cycle address toggling.
        for (int i = 0; i < 8; i++) begin
            enc_keyAddr = (i % 2 == 0) ? 4'd15 : 4'(i);
            push(cyc + 1, 0, (i % 2 == 0) ? 128'd0 : rk_exp(i), ALL, $sformatf("toggle%0d", i));
            wait_cyc(1);
        end
        wait_cyc(1);

        // Zero key loaded from DONE.
        model(256'h0);
        push(cyc, 1, 128'd1, ALL, "z_ready_before");
        load_key('0, t0);
        push(t0 + 1, 1, 128'd0, ALL, "z_ready_drop");
        push_timing(t0, "z");
        wait_cyc(53);
        sweep("z");

        // Second load pulse 20 cycles into EXPAND is ignored.
        model(KEY_A_BE);
        load_key(key_a, t0);
        push_timing(t0, "ign");
        wait_cyc(19);
        key_load = 1'b1;
        key_in   = '0;
        wait_cyc(1);
        key_load = 1'b0;
        wait_cyc(33);
        sweep("ign");

        // Reset asserted 30 cycles into EXPAND.
        enc_keyAddr = 4'd14;
        load_key('0, t0);
        wait_cyc(29);
        resetn = 1'b0;
        push(cyc, 0, 128'd0, ALL, "mid_rst_enc_key");
        push(cyc, 1, 128'd0, ALL, "mid_rst_key_ready");
        push(cyc, 2, 128'd0, ALL, "mid_rst_busy");
        wait_cyc(2);
        push(cyc, 2, 128'd0, ALL, "mid_rst_busy_held");
        resetn = 1'b1;
        wait_cyc(3);
        push(cyc, 1, 128'd0, ALL, "post_rst_idle_ready");
        push(cyc, 2, 128'd0, ALL, "post_rst_idle_busy");
        wait_cyc(1);
        load_key(key_a, t0);
        push_timing(t0, "rl");
        wait_cyc(53);
        enc_keyAddr = 4'd14;
        push(cyc + 1, 0, bswap128(128'hfe4890d1e6188d0b046df344706c631e), ALL, "rl_rk14_gold");
        wait_cyc(2);
        sweep("rl");

        for (int i = 0; i < 20 && sb.size() != 0; i++) wait_cyc(1);
        if (sb.size() != 0) begin
            failures += sb.size();
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
